// File: rtl/fpu_result_checker.sv
// fpu_result_checker: queues golden results and compares them, in order,
// against FPU results. Each compare is classified as an exact match, a
// one-ULP rounding difference, or a mismatch, and counted in statistics
// counters. The last mismatching pair is captured for debug.
module fpu_result_checker #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ExpValid,
  input  logic [31:0]      Expected,
  output logic             ExpReady,
  input  logic             ResValid,
  input  logic [31:0]      Result,
  input  logic             Clear,
  output logic [CNT_W-1:0] NumMatched,
  output logic [CNT_W-1:0] NumRounding,
  output logic [CNT_W-1:0] NumMismatch,
  output logic             MisValid,
  output logic [31:0]      MisResult,
  output logic [31:0]      MisExpected,
  output logic             Overrun,
  output logic             Underrun,
  output logic             Busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    CLS_MATCH    = 2'd0,
    CLS_ROUNDING = 2'd1,
    CLS_MISMATCH = 2'd2
  } cmp_class_t;

  logic [31:0]      fifoMem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      occupancy;
  logic             full;
  logic             empty;
  logic             doPush;
  logic             doPop;

  logic             cmpValid;
  logic [31:0]      cmpExp;
  logic [31:0]      cmpRes;
  logic [31:0]      cmpDiff;
  cmp_class_t       cmpClass;

  assign full     = (occupancy == FULL_COUNT);
  assign empty    = (occupancy == '0);
  assign ExpReady = ~full;
  assign Busy     = ~empty | cmpValid;

  // A pop needs data; a push at full only proceeds when a pop frees a slot.
  assign doPop  = ResValid & ~empty;
  assign doPush = ExpValid & (~full | doPop);

  // Classify the registered pair as raw bit patterns; wrap-around difference catches +/-1 ULP.
  always_comb begin
    cmpDiff  = cmpRes - cmpExp;
    cmpClass = CLS_MISMATCH;
    if (cmpRes == cmpExp) begin
      cmpClass = CLS_MATCH;
    end else if ((cmpDiff == 32'h0000_0001) || (cmpDiff == 32'hFFFF_FFFF)) begin
      cmpClass = CLS_ROUNDING;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (doPush) begin
      fifoMem[wrPtr] <= Expected;
    end
  end

  // Pointers and occupancy; Clear intentionally leaves the queue untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Compare stage captures the popped head with its result on the pop edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmpValid <= 1'b0;
      cmpExp   <= '0;
      cmpRes   <= '0;
    end else begin
      cmpValid <= doPop;
      if (doPop) begin
        cmpExp <= fifoMem[rdPtr];
        cmpRes <= Result;
      end
    end
  end

  // Statistics, mismatch capture and sticky flags; Clear overrides any update this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      NumMatched  <= '0;
      NumRounding <= '0;
      NumMismatch <= '0;
      MisValid    <= 1'b0;
      MisResult   <= '0;
      MisExpected <= '0;
      Overrun     <= 1'b0;
      Underrun    <= 1'b0;
    end else if (Clear) begin
      NumMatched  <= '0;
      NumRounding <= '0;
      NumMismatch <= '0;
      MisValid    <= 1'b0;
      MisResult   <= '0;
      MisExpected <= '0;
      Overrun     <= 1'b0;
      Underrun    <= 1'b0;
    end else begin
      MisValid <= 1'b0;
      if (ExpValid && full && !doPop) begin
        Overrun <= 1'b1;
      end
      if (ResValid && empty) begin
        Underrun <= 1'b1;
      end
      if (cmpValid) begin
        case (cmpClass)
          CLS_MATCH: begin
            if (NumMatched != '1) NumMatched <= NumMatched + CNT_W'(1);
          end
          CLS_ROUNDING: begin
            if (NumRounding != '1) NumRounding <= NumRounding + CNT_W'(1);
          end
          default: begin
            if (NumMismatch != '1) NumMismatch <= NumMismatch + CNT_W'(1);
            MisValid    <= 1'b1;
            MisResult   <= cmpRes;
            MisExpected <= cmpExp;
          end
        endcase
      end
    end
  end

endmodule
